pipe_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage core. Collects stall requests from ID (jump/branch squash, load-use) and from the IF and MEM memory ports, and produces per-register stall/flush vectors. Holds a taken-branch redirect that arrives while the PC is frozen, so it cannot be lost. Adds a memory-wait watchdog and a saturating stall-cycle counter.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_ctrl_stall_watchdog.sv | 69 ++++++
 rtl/pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stall/flush vector
// bit positions, controller state encoding and global enables.
package pipe_ctrl_pkg;

    // Bit positions inside stall_o / flush_o (one bit per pipeline register)
    localparam int STALL_PC     = 0;
    localparam int STALL_IF_ID  = 1;
    localparam int STALL_ID_EX  = 2;
    localparam int STALL_EX_MEM = 3;
    localparam int STALL_MEM_WB = 4;
    localparam int STALL_W      = 5;

    // Global enables; tying one low disables that request source entirely
    localparam logic STALLREQ_ENABLE = 1'b1;
    localparam logic BRANCH_ENABLE   = 1'b1;

    // Controller / watchdog state encoding
    typedef enum logic [1:0] {
        CTRL_RUN      = 2'b00,
        CTRL_MEM_WAIT = 2'b01,
        CTRL_HALT     = 2'b10
    } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Memory-wait watchdog: counts consecutive data-memory stall cycles and
// latches a sticky halt once the wait exceeds MAX_WAIT.
//
//   state         | meaning
//   --------------+-----------------------------------------------------
//   CTRL_RUN      | no memory wait in progress, wait_cnt is zero
//   CTRL_MEM_WAIT | data memory stalling, wait_cnt counts the wait
//   CTRL_HALT     | wait limit exceeded; only reset leaves this state
module pipe_ctrl_stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic memstallreq_i,
    output logic halt_o
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    ctrl_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Next-state and wait counter update
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            CTRL_RUN: begin
                if (memstallreq_i) begin
                    state_d = CTRL_MEM_WAIT;
                end
            end
            CTRL_MEM_WAIT: begin
                if (!memstallreq_i) begin
                    state_d    = CTRL_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    state_d = CTRL_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            CTRL_HALT: begin
                state_d = CTRL_HALT;
            end
            default: begin
                state_d    = CTRL_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= CTRL_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign halt_o = (state_q == CTRL_HALT);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: merges stall requests into per-register
// stall/flush vectors, holds a branch redirect across a frozen PC, and
// counts stalled cycles. All outputs are forced low while rst is asserted.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jbstallreq_i,
    input  logic              lwstallreq_i,
    input  logic              ifstallreq_i,
    input  logic              memstallreq_i,
    input  logic              be_i,
    input  logic [31:0]       baddr_i,
    output logic [4:0]        stall_o,
    output logic [4:0]        flush_o,
    output logic              redirect_o,
    output logic [31:0]       redirect_addr_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    logic               halt;
    logic               jb_req, lw_req, if_req, mem_req, br_taken;
    logic [STALL_W-1:0] stall_vec, flush_vec;
    logic               pend_valid_q, pend_valid_d;
    logic [31:0]        pend_addr_q, pend_addr_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               redirect;
    logic [31:0]        redirect_addr;

    assign jb_req   = jbstallreq_i  & STALLREQ_ENABLE;
    assign lw_req   = lwstallreq_i  & STALLREQ_ENABLE;
    assign if_req   = ifstallreq_i  & STALLREQ_ENABLE;
    assign mem_req  = memstallreq_i & STALLREQ_ENABLE;
    assign br_taken = be_i & BRANCH_ENABLE;

    pipe_ctrl_stall_watchdog #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_stall_watchdog (
        .clk           (clk),
        .rst           (rst),
        .memstallreq_i (mem_req),
        .halt_o        (halt)
    );

    // Priority stall/flush selection; a jump squash coinciding with a
    // load-use or fetch stall is dropped because ID re-raises it.
    always_comb begin
        stall_vec = '0;
        flush_vec = '0;
        if (halt) begin
            stall_vec = '1;
        end else if (mem_req) begin
            stall_vec[STALL_PC]     = 1'b1;
            stall_vec[STALL_IF_ID]  = 1'b1;
            stall_vec[STALL_ID_EX]  = 1'b1;
            stall_vec[STALL_EX_MEM] = 1'b1;
            flush_vec[STALL_MEM_WB] = 1'b1;
        end else if (lw_req) begin
            stall_vec[STALL_PC]     = 1'b1;
            stall_vec[STALL_IF_ID]  = 1'b1;
            flush_vec[STALL_ID_EX]  = 1'b1;
        end else if (if_req) begin
            stall_vec[STALL_PC]     = 1'b1;
            flush_vec[STALL_IF_ID]  = 1'b1;
        end else if (jb_req) begin
            flush_vec[STALL_IF_ID]  = 1'b1;
        end
    end

    // Redirect hold: a taken branch seen while the PC is frozen is parked
    // until the PC can move again, then consumed on that edge.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        if (stall_vec[STALL_PC]) begin
            if (br_taken) begin
                pend_valid_d = 1'b1;
                pend_addr_d  = baddr_i;
            end
        end else begin
            pend_valid_d = 1'b0;
        end
    end

    assign redirect      = (br_taken | pend_valid_q) & ~stall_vec[STALL_PC];
    assign redirect_addr = pend_valid_q ? pend_addr_q : baddr_i;

    // Saturating count of cycles with any stall bit set
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (|stall_vec && (stall_cnt_q != CNT_SAT)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Redirect hold and stall counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // Outputs are held low for the whole reset assertion, not just after
    // the registers clear, so downstream logic never sees stale requests.
    assign stall_o         = rst ? stall_vec     : '0;
    assign flush_o         = rst ? flush_vec     : '0;
    assign redirect_o      = rst & redirect;
    assign redirect_addr_o = rst ? redirect_addr : '0;
    assign err_o           = rst & halt;
    assign stall_cnt_o     = rst ? stall_cnt_q   : '0;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int MW  = 3;
    localparam int CW  = 6;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          jbstallreq_i, lwstallreq_i, ifstallreq_i, memstallreq_i, be_i;
    logic [31:0]   baddr_i;
    logic [4:0]    stall_o, flush_o;
    logic          redirect_o;
    logic [31:0]   redirect_addr_o;
    logic          err_o;
    logic [CW-1:0] stall_cnt_o;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    bit          m_halt;
    bit          m_pend;
    logic [31:0] m_paddr;
    int          m_run;
    int          m_cnt;

    pipe_ctrl #(.MAX_WAIT(MW), .WAIT_W(8), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .jbstallreq_i    (jbstallreq_i),
        .lwstallreq_i    (lwstallreq_i),
        .ifstallreq_i    (ifstallreq_i),
        .memstallreq_i   (memstallreq_i),
        .be_i            (be_i),
        .baddr_i         (baddr_i),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .redirect_o      (redirect_o),
        .redirect_addr_o (redirect_addr_o),
        .err_o           (err_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // priority table from the hazard rules, highest first
    task automatic exp_vec(output logic [4:0] s, output logic [4:0] f);
        if (m_halt)             begin s = 5'b11111; f = 5'b00000; end
        else if (memstallreq_i) begin s = 5'b01111; f = 5'b10000; end
        else if (lwstallreq_i)  begin s = 5'b00011; f = 5'b00100; end
        else if (ifstallreq_i)  begin s = 5'b00001; f = 5'b00010; end
        else if (jbstallreq_i)  begin s = 5'b00000; f = 5'b00010; end
        else                    begin s = 5'b00000; f = 5'b00000; end
    endtask

    task automatic model_reset();
        m_halt  = 1'b0;
        m_pend  = 1'b0;
        m_paddr = '0;
        m_run   = 0;
        m_cnt   = 0;
    endtask

    // advance the model across one rising edge using the inputs of that cycle;
    // m_run counts consecutive edges with the memory stall raised
    task automatic model_edge();
        logic [4:0] s, f;
        exp_vec(s, f);
        if (s != 5'b00000) m_cnt = (m_cnt < SAT) ? m_cnt + 1 : SAT;
        if (s[0]) begin
            if (be_i) begin
                m_pend  = 1'b1;
                m_paddr = baddr_i;
            end
        end else begin
            m_pend = 1'b0;
        end
        if (!m_halt) begin
            if (memstallreq_i) begin
                m_run++;
                if (m_run == MW + 2) m_halt = 1'b1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [4:0] s, f;
        logic       red;
        exp_vec(s, f);
        red = (be_i | m_pend) & ~s[0];
        chk({tag, "_stall"},    32'(stall_o),         32'(s));
        chk({tag, "_flush"},    32'(flush_o),         32'(f));
        chk({tag, "_redirect"}, 32'(redirect_o),      32'(red));
        chk({tag, "_raddr"},    redirect_addr_o,      m_pend ? m_paddr : baddr_i);
        chk({tag, "_err"},      32'(err_o),           32'(m_halt));
        chk({tag, "_cnt"},      32'(stall_cnt_o),     32'(m_cnt));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_stall"},    32'(stall_o),     32'd0);
        chk({tag, "_flush"},    32'(flush_o),     32'd0);
        chk({tag, "_redirect"}, 32'(redirect_o),  32'd0);
        chk({tag, "_raddr"},    redirect_addr_o,  32'd0);
        chk({tag, "_err"},      32'(err_o),       32'd0);
        chk({tag, "_cnt"},      32'(stall_cnt_o), 32'd0);
    endtask

    // one clock cycle: apply inputs just after an edge, check mid-cycle,
    // then step the model on the next rising edge
    task automatic cyc(input logic jb, input logic lw, input logic ifs, input logic mem,
                       input logic be, input logic [31:0] ba, input string tag);
        assert (!(m_pend && be && (ba != m_paddr)))
        else $error("FAIL illegal_branch observed=0x%08h expected=0x%08h", ba, m_paddr);
        jbstallreq_i  = jb;
        lwstallreq_i  = lw;
        ifstallreq_i  = ifs;
        memstallreq_i = mem;
        be_i          = be;
        baddr_i       = ba;
        #3;
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        logic        r_jb, r_lw, r_if, r_mem, r_be;
        logic [31:0] r_ba;

        // reset held with busy inputs: every output must read zero
        rst           = 1'b0;
        jbstallreq_i  = 1'b1;
        lwstallreq_i  = 1'b1;
        ifstallreq_i  = 1'b1;
        memstallreq_i = 1'b1;
        be_i          = 1'b1;
        baddr_i       = 32'hDEAD_BEEC;
        model_reset();
        #2;
        check_zero("rst_hold");
        @(posedge clk);
        #1;
        rst = 1'b1;

        cyc(0, 0, 0, 0, 0, 32'h0, "idle0");

        // load-use, one cycle
        cyc(0, 1, 0, 0, 0, 32'h0, "lw");
        cyc(0, 0, 0, 0, 0, 32'h0, "lw_after");

        // branch taken during fetch wait: parked, then released
        cyc(0, 0, 1, 0, 1, 32'h0000_0040, "if_br");
        cyc(0, 0, 0, 0, 0, 32'h0000_0000, "if_br_next");
        cyc(0, 0, 0, 0, 0, 32'h0000_0000, "pend_clr");

        cyc(1, 1, 0, 0, 0, 32'h0, "lw_jb");
        cyc(1, 0, 0, 0, 0, 32'h0, "jb");
        cyc(1, 0, 1, 0, 0, 32'h0, "if_jb");
        cyc(0, 0, 0, 0, 1, 32'h0000_0100, "br_run");

        // memory stall one cycle short of the trip point, twice in a row
        repeat (MW + 1) cyc(0, 0, 0, 1, 0, 32'h0, "mem_short");
        cyc(0, 0, 0, 0, 0, 32'h0, "mem_short_end");
        repeat (MW + 1) cyc(0, 1, 0, 1, 1, 32'h0000_0200, "mem_short2");
        cyc(0, 0, 0, 0, 0, 32'h0, "mem_short2_end");

        // random traffic, long enough to saturate the stall counter
        for (int i = 0; i < 300; i++) begin
            r_jb  = ($urandom_range(0, 3) == 0);
            r_lw  = ($urandom_range(0, 3) == 0);
            r_if  = ($urandom_range(0, 2) == 0);
            r_mem = ($urandom_range(0, 4) == 0);
            r_be  = ($urandom_range(0, 2) == 0);
            r_ba  = $urandom & 32'hFFFF_FFFC;
            if (m_pend && r_be) r_ba = m_paddr;
            cyc(r_jb, r_lw, r_if, r_mem, r_be, r_ba, "rand");
        end

        rst = 1'b0;
        #1;
        check_zero("rst_rand");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // memory stall long enough to trip the watchdog, then sit in halt
        repeat (MW + 2) cyc(0, 0, 0, 1, 0, 32'h0, "mem_trip");
        repeat (3) cyc(0, 0, 0, 0, 1, 32'h0000_0080, "halt");
        cyc(0, 1, 1, 1, 1, 32'h0000_0080, "halt_busy");

        // asynchronous reset mid-halt with a parked redirect
        memstallreq_i = 1'b1;
        be_i          = 1'b1;
        baddr_i       = 32'h0000_0080;
        #1;
        rst = 1'b0;
        #1;
        check_zero("rst_halt");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, 32'h0, "post_rst");
        cyc(0, 0, 0, 1, 0, 32'h0, "post_rst_mem");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
